// File: rtl/fmul_accumulator.sv
// fmul_accumulator
//   Captures single-precision products on the multiplier's done strobe and
//   adds each one into a running IEEE-754 single-precision sum. The add runs
//   through a fixed three-state pipeline: ALIGN, ADD, NORM.
//   Denormal operands and results are flushed to zero.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   clear      synchronous clear of acc_out / count / err_flags; aborts an add
//   in_data    product word from the multiplier
//   in_flags   {over, under, zero, done}; bit 0 is the capture strobe
//   acc_out    accumulated sum
//   acc_valid  one-cycle pulse after acc_out is updated
//   busy       high while an add is in flight
//   count      products accepted since reset/clear (wraps)
//   err_flags  sticky {drop, in_over, in_under, acc_ovf}
//
// Build option
//   FMUL_ACC_RNE_EN  defined: round-to-nearest-even in NORM.
//                    undefined: truncate. Latency is the same in both builds.

module fmul_accumulator #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [31:0]      in_data,
    input  logic [3:0]       in_flags,
    output logic [31:0]      acc_out,
    output logic             acc_valid,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic [3:0]       err_flags
);

    typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM} state_t;

    state_t r_state, w_next;

    logic        w_strobe, w_accept, w_drop, w_zero_op;
    logic [31:0] r_b;
    logic [26:0] r_ml, r_ms;
    logic [7:0]  r_exp;
    logic        r_sign, r_sub;
    logic [27:0] r_sum;

    // clear beats a simultaneous strobe
    assign w_strobe  = in_flags[0] & ~clear;
    assign w_accept  = w_strobe & (r_state == S_IDLE);
    assign w_drop    = w_strobe & (r_state != S_IDLE);
    assign w_zero_op = in_flags[3] | in_flags[2] | in_flags[1] | (in_data[30:23] == 8'd0);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (clear) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept && !w_zero_op) w_next = S_ALIGN;
                S_ALIGN: w_next = S_ADD;
                S_ADD:   w_next = S_NORM;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (r_state != S_IDLE);
    end

    // ---------------- ALIGN ----------------
    logic        w_b_big;
    logic [26:0] w_ma, w_mb, w_ml, w_msr, w_msa, w_mask;
    logic [7:0]  w_el, w_d;

    always_comb begin
        // an accumulator with exponent 0 is zero, so its mantissa has no hidden bit
        w_ma    = (acc_out[30:23] == 8'd0) ? 27'd0 : {1'b1, acc_out[22:0], 3'b000};
        w_mb    = {1'b1, r_b[22:0], 3'b000};
        // strict compare so that equal magnitudes pick the accumulator
        w_b_big = r_b[30:0] > acc_out[30:0];
        w_ml    = w_b_big ? w_mb : w_ma;
        w_msr   = w_b_big ? w_ma : w_mb;
        w_el    = w_b_big ? r_b[30:23] : acc_out[30:23];
        w_d     = w_b_big ? (r_b[30:23] - acc_out[30:23]) : (acc_out[30:23] - r_b[30:23]);
        w_mask  = '0;
        if (w_d >= 8'd27) begin
            w_msa = {26'd0, |w_msr};
        end else begin
            w_mask = ~(27'h7FF_FFFF << w_d[4:0]);
            w_msa  = (w_msr >> w_d[4:0]) | {26'd0, |(w_msr & w_mask)};
        end
    end

    // ---------------- NORM ----------------
    logic [4:0]        w_lz;
    logic [26:0]       w_nm;
    logic signed [9:0] w_ne, w_fe;
    logic              w_rnd;
    logic [24:0]       w_m25;
    logic [31:0]       w_res;
    logic              w_ovf;
    logic              w_unused;

    always_comb begin
        w_lz = 5'd0;
        for (int i = 0; i < 27; i++) if (r_sum[i]) w_lz = 5'(26 - i);
    end

    always_comb begin
        if (r_sum[27]) begin
            w_nm = {r_sum[27:2], r_sum[1] | r_sum[0]};
            w_ne = $signed({2'b00, r_exp}) + 10'sd1;
        end else begin
            w_nm = r_sum[26:0] << w_lz;
            w_ne = $signed({2'b00, r_exp}) - $signed({5'd0, w_lz});
        end
`ifdef FMUL_ACC_RNE_EN
        w_rnd = w_nm[2] & (w_nm[1] | w_nm[0] | w_nm[3]);
`else
        w_rnd = 1'b0;
`endif
        // a rounding carry leaves mantissa 1.0, so the fraction is zero
        w_m25 = {1'b0, w_nm[26:3]} + {24'd0, w_rnd};
        w_fe  = w_m25[24] ? (w_ne + 10'sd1) : w_ne;
        w_ovf = 1'b0;
        if (r_sum == 28'd0) begin
            w_res = 32'd0;
        end else if (w_fe >= 10'sd255) begin
            w_res = {r_sign, 8'hFE, 23'h7F_FFFF};
            w_ovf = 1'b1;
        end else if (w_fe <= 10'sd0) begin
            w_res = {r_sign, 31'd0};
        end else begin
            w_res = {r_sign, w_fe[7:0], (w_m25[24] ? 23'd0 : w_m25[22:0])};
        end
    end

    assign w_unused = ^{w_m25[23], w_nm[2:0]};

    // ---------------- datapath / status ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_out   <= 32'd0;
            acc_valid <= 1'b0;
            count     <= '0;
            err_flags <= 4'd0;
            r_b       <= 32'd0;
            r_ml      <= 27'd0;
            r_ms      <= 27'd0;
            r_exp     <= 8'd0;
            r_sign    <= 1'b0;
            r_sub     <= 1'b0;
            r_sum     <= 28'd0;
        end else begin
            acc_valid <= 1'b0;
            if (clear) begin
                acc_out   <= 32'd0;
                count     <= '0;
                err_flags <= 4'd0;
            end else begin
                if (w_drop) err_flags[3] <= 1'b1;
                if (w_accept) begin
                    count <= count + 1'b1;
                    if (in_flags[3]) err_flags[2] <= 1'b1;
                    if (in_flags[2]) err_flags[1] <= 1'b1;
                    // zero operands leave the sum unchanged
                    if (w_zero_op) acc_valid <= 1'b1;
                    else           r_b       <= in_data;
                end
                case (r_state)
                    S_ALIGN: begin
                        r_ml   <= w_ml;
                        r_ms   <= w_msa;
                        r_exp  <= w_el;
                        r_sign <= w_b_big ? r_b[31] : acc_out[31];
                        r_sub  <= r_b[31] ^ acc_out[31];
                    end
                    S_ADD: begin
                        r_sum <= r_sub ? ({1'b0, r_ml} - {1'b0, r_ms})
                                       : ({1'b0, r_ml} + {1'b0, r_ms});
                    end
                    S_NORM: begin
                        acc_out   <= w_res;
                        acc_valid <= 1'b1;
                        if (w_ovf) err_flags[0] <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fmul_accumulator.sv
module tb_fmul_accumulator;

    localparam int CNT_W = 16;
`ifdef FMUL_ACC_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic [31:0]      in_data;
    logic [3:0]       in_flags;
    logic [31:0]      acc_out;
    logic             acc_valid;
    logic             busy;
    logic [CNT_W-1:0] count;
    logic [3:0]       err_flags;

    int n_cmp = 0;
    int n_err = 0;

    fmul_accumulator #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_flags(in_flags),
        .acc_out(acc_out), .acc_valid(acc_valid), .busy(busy), .count(count),
        .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    // Reference: exact sum of the two values as a wide integer (unit 2^-149),
    // then rounded once to single precision with the block's flush/saturate rules.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                            output bit ovf);
        logic [299:0] ma, mb, mag, sh, lowm;
        logic         s;
        int           p, e;
        logic [24:0]  m;
        bit           g, st;
        ovf = 1'b0;
        ma  = '0;
        mb  = '0;
        if (a[30:23] != 8'd0) begin ma = {276'd0, 1'b1, a[22:0]}; ma = ma << (a[30:23] - 1); end
        if (b[30:23] != 8'd0) begin mb = {276'd0, 1'b1, b[22:0]}; mb = mb << (b[30:23] - 1); end
        if (a[31] == b[31])  begin mag = ma + mb; s = a[31]; end
        else if (ma >= mb)   begin mag = ma - mb; s = a[31]; end
        else                 begin mag = mb - ma; s = b[31]; end
        if (mag == '0) return 32'd0;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e  = p - 22;
        g  = 1'b0;
        st = 1'b0;
        if (p >= 23) sh = mag >> (p - 23);
        else         sh = mag << (23 - p);
        m = {1'b0, sh[23:0]};
        if (p >= 24) begin
            g    = mag[p-24];
            lowm = (300'd1 << (p - 24)) - 300'd1;
            st   = |(mag & lowm);
        end
        if (RNE && g && (st || m[0])) m = m + 25'd1;
        if (m[24]) begin m = 25'h080_0000; e++; end
        if (e >= 255) begin ovf = 1'b1; return {s, 8'hFE, 23'h7F_FFFF}; end
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], m[22:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic strobe(input logic [31:0] d, input logic [3:0] f);
        in_data  = d;
        in_flags = f;
        tick();
        in_flags = 4'd0;
    endtask

    // cycles from just after the capture edge until acc_valid is seen; 8 = timeout
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!acc_valid && lat < 8) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; in_data = 32'd0; in_flags = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (acc_out !== 32'd0) begin n_err++; $display("FAIL reset_acc: got %h want 00000000", acc_out); end
        n_cmp++; if (acc_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", acc_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (count !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (err_flags !== 4'd0) begin n_err++; $display("FAIL reset_err: got %b want 0000", err_flags); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_sum();
        int lat;
        do_clear();
        strobe(32'h3F80_0000, 4'b0001);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", busy); end
        wait_valid(lat);
        n_cmp++; if (lat != 3) begin n_err++; $display("FAIL basic_lat1: got %0d want 3", lat); end
        n_cmp++; if (acc_out !== 32'h3F80_0000) begin n_err++; $display("FAIL basic_acc1: got %h want 3f800000", acc_out); end
        tick();
        n_cmp++; if (acc_valid !== 1'b0) begin n_err++; $display("FAIL basic_pulse: got %b want 0", acc_valid); end
        strobe(32'h4000_0000, 4'b0001);
        wait_valid(lat);
        n_cmp++; if (lat != 3) begin n_err++; $display("FAIL basic_lat2: got %0d want 3", lat); end
        n_cmp++; if (acc_out !== 32'h4040_0000) begin n_err++; $display("FAIL basic_acc2: got %h want 40400000", acc_out); end
        n_cmp++; if (count !== 16'd2) begin n_err++; $display("FAIL basic_count: got %0d want 2", count); end
    endtask

    task automatic test_cancel();
        int lat;
        do_clear();
        strobe(32'h3FC0_0000, 4'b0001); wait_valid(lat);
        strobe(32'hBFC0_0000, 4'b0001); wait_valid(lat);
        n_cmp++; if (acc_out !== 32'h0000_0000) begin n_err++; $display("FAIL cancel_acc: got %h want 00000000", acc_out); end
    endtask

    task automatic test_rounding();
        int lat;
        logic [31:0] want;
        want = RNE ? 32'h3F80_0001 : 32'h3F80_0000;
        do_clear();
        strobe(32'h3F80_0000, 4'b0001); wait_valid(lat);
        strobe(32'h33C0_0000, 4'b0001); wait_valid(lat);
        n_cmp++; if (acc_out !== want) begin n_err++; $display("FAIL round_acc: got %h want %h", acc_out, want); end
    endtask

    task automatic test_overflow();
        int lat;
        do_clear();
        strobe(32'h7F7F_FFFF, 4'b0001); wait_valid(lat);
        strobe(32'h7F7F_FFFF, 4'b0001); wait_valid(lat);
        n_cmp++; if (acc_out !== 32'h7F7F_FFFF) begin n_err++; $display("FAIL ovf_acc: got %h want 7f7fffff", acc_out); end
        n_cmp++; if (err_flags !== 4'b0001) begin n_err++; $display("FAIL ovf_err: got %b want 0001", err_flags); end
    endtask

    task automatic test_flags_drop();
        int lat;
        do_clear();
        strobe(32'h3F80_0000, 4'b0001); wait_valid(lat);
        strobe(32'h40A0_0000, 4'b1001);
        n_cmp++; if (acc_valid !== 1'b1) begin n_err++; $display("FAIL over_valid: got %b want 1", acc_valid); end
        n_cmp++; if (acc_out !== 32'h3F80_0000) begin n_err++; $display("FAIL over_acc: got %h want 3f800000", acc_out); end
        n_cmp++; if (err_flags !== 4'b0100) begin n_err++; $display("FAIL over_err: got %b want 0100", err_flags); end
        n_cmp++; if (count !== 16'd2) begin n_err++; $display("FAIL over_count: got %0d want 2", count); end
        strobe(32'h1234_5678, 4'b0101);
        n_cmp++; if (err_flags !== 4'b0110) begin n_err++; $display("FAIL under_err: got %b want 0110", err_flags); end
        strobe(32'h0040_0000, 4'b0001);
        n_cmp++; if (acc_valid !== 1'b1 || acc_out !== 32'h3F80_0000) begin
            n_err++; $display("FAIL denorm_zero: got valid %b acc %h want 1 3f800000", acc_valid, acc_out); end
        n_cmp++; if (count !== 16'd4) begin n_err++; $display("FAIL denorm_count: got %0d want 4", count); end
        strobe(32'h4000_0000, 4'b0001);
        strobe(32'h4080_0000, 4'b0001);
        wait_valid(lat);
        n_cmp++; if (acc_out !== 32'h4040_0000) begin n_err++; $display("FAIL drop_acc: got %h want 40400000", acc_out); end
        n_cmp++; if (err_flags !== 4'b1110) begin n_err++; $display("FAIL drop_err: got %b want 1110", err_flags); end
        n_cmp++; if (count !== 16'd5) begin n_err++; $display("FAIL drop_count: got %0d want 5", count); end
    endtask

    task automatic test_clear_abort();
        int lat;
        bit seen;
        strobe(32'h0000_0000, 4'b1001);
        strobe(32'h3F80_0000, 4'b0001); wait_valid(lat);
        strobe(32'h4000_0000, 4'b0001);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (acc_out !== 32'd0) begin n_err++; $display("FAIL abort_acc: got %h want 00000000", acc_out); end
        n_cmp++; if (count !== '0) begin n_err++; $display("FAIL abort_count: got %0d want 0", count); end
        n_cmp++; if (err_flags !== 4'd0) begin n_err++; $display("FAIL abort_err: got %b want 0000", err_flags); end
        seen = acc_valid;
        for (int i = 0; i < 5; i++) begin tick(); if (acc_valid) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_novalid: got %b want 0", seen); end
        clear = 1'b1; in_data = 32'h3F80_0000; in_flags = 4'b0001;
        tick();
        clear = 1'b0; in_flags = 4'd0;
        n_cmp++; if (count !== '0 || busy !== 1'b0) begin
            n_err++; $display("FAIL clear_strobe: got count %0d busy %b want 0 0", count, busy); end
        repeat (4) tick();
        n_cmp++; if (acc_out !== 32'd0) begin n_err++; $display("FAIL clear_strobe_acc: got %h want 00000000", acc_out); end
    endtask

    task automatic test_rst_mid();
        int lat;
        strobe(32'h0000_0000, 4'b0101);
        strobe(32'h3F80_0000, 4'b0001); wait_valid(lat);
        strobe(32'h4000_0000, 4'b0001);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (acc_out !== 32'd0 || acc_valid !== 1'b0 || busy !== 1'b0 || count !== '0 || err_flags !== 4'd0) begin
            n_err++; $display("FAIL rst_mid: got acc %h v %b busy %b cnt %0d err %b want all zero",
                              acc_out, acc_valid, busy, count, err_flags); end
        #2;
        rst = 1'b0;
        tick();
        strobe(32'h4000_0000, 4'b0001);
        wait_valid(lat);
        n_cmp++; if (lat != 3 || acc_out !== 32'h4000_0000) begin
            n_err++; $display("FAIL rst_recover: got lat %0d acc %h want 3 40000000", lat, acc_out); end
    endtask

    task automatic test_random();
        logic [31:0]      mdl, d, want;
        logic [CNT_W-1:0] mcnt;
        logic [3:0]       merr, f;
        bit               ovf;
        int               lat, wlat;
        do_clear();
        mdl = 32'd0; mcnt = '0; merr = 4'd0;
        for (int k = 0; k < 60; k++) begin
            d = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
            mcnt++;
            if ($urandom_range(0, 7) == 0) begin
                f = {3'($urandom_range(1, 7)), 1'b1};
                merr[2] = merr[2] | f[3];
                merr[1] = merr[1] | f[2];
                want = mdl;
                wlat = 0;
            end else begin
                f = 4'b0001;
                want = ref_add(mdl, d, ovf);
                if (ovf) merr[0] = 1'b1;
                mdl = want;
                wlat = 3;
            end
            strobe(d, f);
            wait_valid(lat);
            n_cmp++; if (lat != wlat) begin n_err++; $display("FAIL rand_lat[%0d]: got %0d want %0d", k, lat, wlat); end
            n_cmp++; if (acc_out !== want) begin n_err++; $display("FAIL rand_acc[%0d]: in %h got %h want %h", k, d, acc_out, want); end
        end
        n_cmp++; if (count !== mcnt) begin n_err++; $display("FAIL rand_count: got %0d want %0d", count, mcnt); end
        n_cmp++; if (err_flags !== merr) begin n_err++; $display("FAIL rand_err: got %b want %b", err_flags, merr); end
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_cancel();
        test_rounding();
        test_overflow();
        test_flags_drop();
        test_clear_abort();
        test_rst_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
